// File: rtl/score_sched_pkg.sv
// Shared types and constants for the score event scheduler: FSM states,
// requester indices, default point weights and pending-register limits.
package score_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    PAUSE = 2'd2
  } sched_state_e;

  localparam int NUM_REQ_C      = 4;
  localparam int PEND_W_DEF     = 8;
  localparam int PEND_MAX       = (1 << PEND_W_DEF) - 1;
  localparam int BONUS_STEP_DEF = 100;

  localparam int REQ_PELLET = 0;
  localparam int REQ_POWER  = 1;
  localparam int REQ_GHOST  = 2;
  localparam int REQ_FRUIT  = 3;

  localparam int W_PELLET = 1;
  localparam int W_POWER  = 5;
  localparam int W_GHOST  = 20;
  localparam int W_FRUIT  = 10;

endpackage

// File: rtl/score_event_scheduler_rr_arbiter.sv
// 4-way round-robin selector: scans from ptr, skips requesters whose
// eligibility bit is low, returns a one-hot grant and the pointer after it.
module rr_arbiter (
  input  logic [3:0] req,
  input  logic [3:0] elig,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] next_ptr
);

  logic [1:0] idx;
  logic       found;

  // NOTE: every variable written here gets a default first, so no path
  // through the loop can leave one unassigned and infer a latch.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx] && elig[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/score_event_scheduler.sv
// Accepts game-event point requests round-robin, accumulates their weights and
// drains them as one-point increase pulses. Optional bonus-life counter under
// the SCORE_BONUS_LIFE_EN macro.
module score_event_scheduler
  import score_sched_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_C,
  parameter int W0         = W_PELLET,
  parameter int W1         = W_POWER,
  parameter int W2         = W_GHOST,
  parameter int W3         = W_FRUIT,
  parameter int PEND_W     = PEND_W_DEF,
  parameter int BONUS_STEP = BONUS_STEP_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [NUM_REQ-1:0] req,
  input  logic               freeze,
  input  logic               saturated,
  output logic [NUM_REQ-1:0] ack,
  output logic               increase,
  output logic               busy,
  output logic               bonus_life
);

  localparam int pend_max_c = (1 << PEND_W) - 1;
  localparam logic [PEND_W:0]   pend_max_v = (PEND_W+1)'(pend_max_c);
  localparam logic [PEND_W-1:0] w0_v = PEND_W'(W0);
  localparam logic [PEND_W-1:0] w1_v = PEND_W'(W1);
  localparam logic [PEND_W-1:0] w2_v = PEND_W'(W2);
  localparam logic [PEND_W-1:0] w3_v = PEND_W'(W3);

  if (NUM_REQ != 4) begin : g_bad_num_req
    $error("score_event_scheduler supports exactly 4 requesters");
  end
  if (W0 > pend_max_c || W1 > pend_max_c || W2 > pend_max_c || W3 > pend_max_c) begin : g_bad_weight
    $error("score_event_scheduler: a weight exceeds the pending register range");
  end

  sched_state_e      state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [1:0]        rr_q, rr_d;
  logic              increase_q, increase_d;
  logic              busy_q, busy_d;

  logic              run, has_pend, drain;
  logic [PEND_W-1:0] drain_base, gnt_w;
  logic [3:0]        req_g, elig, gnt;
  logic [1:0]        next_ptr;

  rr_arbiter u_arb (
    .req      (req_g),
    .elig     (elig),
    .ptr      (rr_q),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  always_comb begin
    run      = resetN && !freeze && !saturated;
    has_pend = (state_q != IDLE) && (pending_q != '0);
    // Fit is judged against pending after this cycle's own drain, if any.
    drain_base = (run && has_pend) ? pending_q - PEND_W'(1) : pending_q;
    req_g      = run ? req : '0;
    elig[0]    = ({1'b0, drain_base} + {1'b0, w0_v}) <= pend_max_v;
    elig[1]    = ({1'b0, drain_base} + {1'b0, w1_v}) <= pend_max_v;
    elig[2]    = ({1'b0, drain_base} + {1'b0, w2_v}) <= pend_max_v;
    elig[3]    = ({1'b0, drain_base} + {1'b0, w3_v}) <= pend_max_v;

    gnt_w = ({PEND_W{gnt[0]}} & w0_v) | ({PEND_W{gnt[1]}} & w1_v) |
            ({PEND_W{gnt[2]}} & w2_v) | ({PEND_W{gnt[3]}} & w3_v);

    // A grant from idle starts draining in the same cycle.
    drain      = run && (has_pend || (|gnt));
    increase_d = drain;
    pending_d  = (saturated && !freeze) ? '0 : pending_q + gnt_w - PEND_W'(drain);
    rr_d       = next_ptr;
    busy_d     = (pending_d != '0) || increase_d;

    state_d = IDLE;
    if (freeze)                 state_d = PAUSE;
    else if (pending_d != '0)   state_d = DRAIN;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      rr_q       <= '0;
      increase_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      increase_q <= increase_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = gnt;
  assign increase = increase_q;
  assign busy     = busy_q;

`ifdef SCORE_BONUS_LIFE_EN
  localparam int bonus_w = $clog2(BONUS_STEP);

  logic [bonus_w-1:0] bonus_cnt_q, bonus_cnt_d;
  logic               bonus_q, bonus_d;

  // Advances only on emitted points, so freeze and saturation hold it.
  always_comb begin
    bonus_cnt_d = bonus_cnt_q;
    bonus_d     = 1'b0;
    if (increase_d) begin
      if (bonus_cnt_q == bonus_w'(BONUS_STEP - 1)) begin
        bonus_cnt_d = '0;
        bonus_d     = 1'b1;
      end else begin
        bonus_cnt_d = bonus_cnt_q + bonus_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bonus_cnt_q <= '0;
      bonus_q     <= 1'b0;
    end else begin
      bonus_cnt_q <= bonus_cnt_d;
      bonus_q     <= bonus_d;
    end
  end

  assign bonus_life = bonus_q;
`else
  assign bonus_life = 1'b0;
`endif

endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed self-checking bench for score_event_scheduler; expected values are
// hand-derived cycle counts. Builds with or without SCORE_BONUS_LIFE_EN.
module tb_score_event_scheduler;
  import score_sched_pkg::*;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] req = 4'b1111;
  logic       freeze = 1'b0;
  logic       saturated = 1'b0;
  logic [3:0] ack;
  logic       increase, busy, bonus_life;

  int checks = 0;
  int errors = 0;

  logic [3:0] ack_s;
  logic       inc_s, busy_s, bonus_s;

  int pulses, first_inc, last_inc, frozen_inc, frozen_ack, wait_k;
  int bonus_n, bonus_at, bonus_bad, bad_busy;
  logic [3:0] r;

  always #5 clk = ~clk;

  score_event_scheduler dut (
    .clk        (clk),
    .resetN     (resetN),
    .req        (req),
    .freeze     (freeze),
    .saturated  (saturated),
    .ack        (ack),
    .increase   (increase),
    .busy       (busy),
    .bonus_life (bonus_life)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, then sample every output.
  task automatic tick(input logic [3:0] rq, input logic frz, input logic sat);
    @(negedge clk);
    req = rq; freeze = frz; saturated = sat;
    #1;
    ack_s = ack; inc_s = increase; busy_s = busy; bonus_s = bonus_life;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0; req = '0; freeze = 1'b0; saturated = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, with requests pending to prove ack is masked.
    #1;
    check("rst_ack", ack, 0);
    check("rst_increase", increase, 0);
    check("rst_busy", busy, 0);
    check("rst_bonus", bonus_life, 0);
    do_reset();

    // Single pellet at cycle 5.
    for (int i = 0; i < 5; i++) tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
    check("pellet_ack", ack_s, 4'b0001);
    check("pellet_inc_c5", inc_s, 0);
    tick(4'b0000, 1'b0, 1'b0);
    check("pellet_inc_c6", inc_s, 1);
    check("pellet_busy_c6", busy_s, 1);
    tick(4'b0000, 1'b0, 1'b0);
    check("pellet_inc_c7", inc_s, 0);
    check("pellet_busy_c7", busy_s, 0);

    // All four at once, each held until acked.
    do_reset();
    r = 4'b1111; pulses = 0; first_inc = -1; last_inc = -1;
    for (int c = 0; c < 42; c++) begin
      tick(r, 1'b0, 1'b0);
      if (c < 5) check($sformatf("rr_ack_c%0d", c), ack_s, (c < 4) ? (32'd1 << c) : 32'd0);
      r = r & ~ack_s;
      if (inc_s) begin
        pulses++;
        if (first_inc < 0) first_inc = c;
        last_inc = c;
      end
    end
    check("rr_pulses", pulses, 36);
    check("rr_first_inc", first_inc, 1);
    check("rr_last_inc", last_inc, 36);

    // Overflow and skip: build pending to 250, then pellet + ghost.
    do_reset();
    wait_k = 0;
    for (int i = 0; i < 12; i++) begin tick(4'b0100, 1'b0, 1'b0); if (ack_s == 4'b0100) wait_k++; end
    for (int i = 0; i < 2; i++)  begin tick(4'b1000, 1'b0, 1'b0); if (ack_s == 4'b1000) wait_k++; end
    tick(4'b0010, 1'b0, 1'b0); if (ack_s == 4'b0010) wait_k++;
    check("ovf_setup_acks", wait_k, 15);
    tick(4'b0101, 1'b0, 1'b0);
    check("ovf_ack_pellet_only", ack_s, 4'b0001);
    pulses = 0; wait_k = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(4'b0100, 1'b0, 1'b0);
      if (inc_s) pulses++;
      if (ack_s != 4'b0000) begin
        check("ovf_ghost_ack_value", ack_s, 4'b0100);
        wait_k = k;
        break;
      end
    end
    check("ovf_ghost_defer_cycles", wait_k, 15);
    begin : drain_ovf
      for (int k = 0; k < 400; k++) begin
        tick(4'b0000, 1'b0, 1'b0);
        if (inc_s) pulses++;
        if (!busy_s) disable drain_ovf;
      end
      check("ovf_drain_timeout", 1, 0);
    end
    check("ovf_total_pulses", pulses, 271);

    // Freeze after 7 pulses of a ghost event, for 10 cycles.
    do_reset();
    tick(4'b0100, 1'b0, 1'b0);
    check("frz_ghost_ack", ack_s, 4'b0100);
    pulses = 0; frozen_inc = 0; frozen_ack = 0; first_inc = -1;
    for (int j = 1; j <= 6; j++) begin tick(4'b0000, 1'b0, 1'b0); if (inc_s) pulses++; end
    for (int j = 7; j <= 16; j++) begin
      tick(4'b0001, 1'b1, 1'b0);
      if (j == 7 && inc_s) pulses++;
      if (j > 7 && inc_s) frozen_inc++;
      if (ack_s != 4'b0000) frozen_ack++;
      if (j == 12) check("frz_busy_held", busy_s, 1);
    end
    check("frz_pulses_before", pulses, 7);
    tick(4'b0000, 1'b0, 1'b0);
    if (inc_s) frozen_inc++;
    check("frz_no_inc", frozen_inc, 0);
    check("frz_no_ack", frozen_ack, 0);
    pulses = 0;
    for (int j = 18; j <= 31; j++) begin
      tick(4'b0000, 1'b0, 1'b0);
      if (inc_s) begin pulses++; if (first_inc < 0) first_inc = j; end
    end
    check("frz_resume_pulses", pulses, 13);
    check("frz_resume_cycle", first_inc, 18);
    check("frz_end_busy", busy_s, 0);

    // Saturation flushes 40 pending points and blocks grants.
    do_reset();
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    check("sat_setup_power_ack", ack_s, 4'b0010);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b1);
    check("sat_ack_blocked", ack_s, 0);
    check("sat_last_inc", inc_s, 1);
    pulses = 0; frozen_ack = 0; bad_busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick(4'b0010, 1'b0, 1'b1);
      if (inc_s) pulses++;
      if (busy_s) bad_busy++;
      if (ack_s != 4'b0000) frozen_ack++;
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1'b0, 1'b0);
      if (inc_s) pulses++;
      if (busy_s) bad_busy++;
    end
    check("sat_no_inc", pulses, 0);
    check("sat_no_busy", bad_busy, 0);
    check("sat_no_ack", frozen_ack, 0);

    // 105 points: five ghosts and a power pellet.
    do_reset();
    pulses = 0; bonus_n = 0; bonus_at = 0; bonus_bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick((i < 5) ? 4'b0100 : ((i == 5) ? 4'b0010 : 4'b0000), 1'b0, 1'b0);
      if (inc_s) pulses++;
      if (bonus_s) begin bonus_n++; bonus_at = pulses; if (!inc_s) bonus_bad++; end
    end
    begin : drain_bonus
      for (int k = 0; k < 200; k++) begin
        tick(4'b0000, 1'b0, 1'b0);
        if (inc_s) pulses++;
        if (bonus_s) begin bonus_n++; bonus_at = pulses; if (!inc_s) bonus_bad++; end
        if (!busy_s) disable drain_bonus;
      end
      check("bonus_drain_timeout", 1, 0);
    end
    check("bonus_total_pulses", pulses, 105);
    check("bonus_with_increase", bonus_bad, 0);
`ifdef SCORE_BONUS_LIFE_EN
    check("bonus_count", bonus_n, 1);
    check("bonus_on_100th", bonus_at, 100);
`else
    check("bonus_absent", bonus_n, 0);
`endif

    // Asynchronous reset in the middle of a drain.
    do_reset();
    tick(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(4'b0000, 1'b0, 1'b0);
    check("mid_inc_before_rst", inc_s, 1);
    @(posedge clk);
    #2;
    resetN = 1'b0; req = 4'b1111;
    #1;
    check("async_rst_increase", increase, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_bonus", bonus_life, 0);
    check("async_rst_ack", ack, 0);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    resetN = 1'b1;
    pulses = 0; bad_busy = 0;
    for (int i = 0; i < 25; i++) begin
      tick(4'b0000, 1'b0, 1'b0);
      if (inc_s) pulses++;
      if (busy_s) bad_busy++;
    end
    check("post_rst_no_inc", pulses, 0);
    check("post_rst_no_busy", bad_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_event_scheduler.md
# score_event_scheduler

Arbitrates game-event point requests (pellet, power pellet, ghost, fruit) and sequences them into single-cycle `increase` pulses for the BCD score counter. Simultaneous events are accepted one per cycle in round-robin order, their point weights are accumulated in a pending register, and that register is drained at one point per clock. The block sits between the game-logic collision detectors and the three-digit score counter.

## Interface
- `NUM_REQ`, 4: number of requesters (fixed at 4).
- `W0`, 1: points for req[0] (pellet).
- `W1`, 5: points for req[1] (power pellet).
- `W2`, 20: points for req[2] (ghost).
- `W3`, 10: points for req[3] (fruit).
- `PEND_W`, 8: pending register width; PEND_MAX = 2^PEND_W − 1 = 255.
- `BONUS_STEP`, 100: points per bonus life (macro-dependent).

- `clk` in 1: clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `req` in 4: per-requester level request, held until acked.
- `freeze` in 1: game paused; no grants, no drain.
- `saturated` in 1: score counter reads 999.
- `ack` out 4: one-hot combinational accept strobe.
- `increase` out 1: registered one-cycle pulse, one score point.
- `busy` out 1: registered; pending ≠ 0.
- `bonus_life` out 1: registered one-cycle pulse (only with macro).

## Operation
- States: IDLE (pending = 0), DRAIN (pending > 0), PAUSE (freeze = 1). PAUSE is entered from any state when freeze = 1 and returns to IDLE or DRAIN, chosen by pending, when freeze = 0.
- Grant, in IDLE or DRAIN only, when saturated = 0:
  - Scan req starting at rr_ptr, wrapping.
  - The first requester i with pending_next_base + Wi ≤ PEND_MAX wins.
  - pending_next_base = pending − (drain this cycle ? 1 : 0).
  - At most one grant per cycle. ack[i] = 1 in that cycle only.
  - rr_ptr ← (i+1) mod 4 on grant; unchanged otherwise.
- Requesters whose weight does not fit are skipped, not blocked. They are retried every cycle.
- Drain: in DRAIN with freeze = 0 and saturated = 0, assert increase next cycle and decrement pending.
- Simultaneous grant and drain: pending ← pending + Wi − 1.
- saturated = 1: pending flushed to 0 at the next edge (points lost), no grants, ack = 0, increase = 0.
- freeze = 1: ack = 0, increase = 0. Pending and rr_ptr are held.
- A requester must drop req in the cycle after seeing ack. A held req is re-accepted as a new event.
- All arithmetic is unsigned PEND_W bits. Wi ≤ PEND_MAX is checked at elaboration.

## Timing
- Reset values:
  - increase = 0, busy = 0, bonus_life = 0.
  - pending = 0, rr_ptr = 0, state = IDLE.
  - Bonus counter = 0.
  - ack is combinational and 0 during reset.
- Latency: req rises at cycle n with the block idle → ack at n. The first increase is high from edge n+1 to n+2. An event of weight W yields W pulses in cycles n+1 … n+W, with no other traffic.
- busy is high in the cycle after any grant while pending > 0. It drops in the cycle after the last pulse.
- Reset mid-drain: remaining points are discarded and the block returns to IDLE immediately (asynchronous).

## Configuration
- `SCORE_BONUS_LIFE_EN` defined:
  - A modulo-BONUS_STEP counter advances on each increase.
  - bonus_life pulses in the same cycle as the increase that wraps it to 0.
  - The counter is held under freeze and saturated, and reset only by resetN.
- Not defined: the bonus counter is absent and the bonus_life port is tied to 0.

## Structure
- Package `score_sched_pkg` holds:
  - the state enum (IDLE, DRAIN, PAUSE);
  - the PEND_MAX constant;
  - the requester index constants (REQ_PELLET = 0, REQ_POWER = 1, REQ_GHOST = 2, REQ_FRUIT = 3);
  - the default weight constants.
- Sub-module `rr_arbiter`: a 4-way round-robin priority selector with an eligibility mask input (fit check). It outputs a one-hot grant and the next pointer.

## Test plan
- Single pellet: req = 0001 at cycle 5 → ack[0] at cycle 5, one increase at cycle 6, busy high in cycle 6 only.
- Simultaneous events: req = 1111 held until acked → acks in order 0, 1, 2, 3 on cycles n … n+3. There are 36 increase pulses in total, back-to-back from n+1 to n+36.
- Overflow and skip (each step: setup → required response):
  - pending = 250, req = 0101 → req[0] acked, req[2] deferred.
  - After pending ≤ 235 → req[2] acked.
  - Total pulses = 250 + 1 + 20.
- Freeze mid-drain: ghost event, then freeze = 1 after 7 pulses for 10 cycles → no increase or ack during freeze. The 13 remaining pulses resume in the cycle after freeze = 0.
- Saturation: pending = 40, saturated = 1 → pending = 0, busy = 0, increase = 0 from the next cycle. req[1] is not acked while saturated.
- Bonus (macro on) and reset: issue 105 points → bonus_life pulses exactly once, on the 100th increase. Assert resetN low during drain → all outputs 0 asynchronously, and no pulses follow after release.
